// File: rtl/bus_port_fifo.sv
// bus_port_fifo: per-device bus port adapter with a TX FIFO toward the bus,
// an address-filtered RX FIFO toward the device, and a saturating drop counter.
module bus_port_fifo #(
    parameter int          pckg_sz = 16,
    parameter int          depth   = 8,
    parameter logic [7:0]  id      = 8'd0,
    parameter logic [7:0]  bc_id   = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd,
    output logic               rx_full,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic [15:0]        drop_cnt
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [aw-1:0] last_ptr = aw'(depth - 1);
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];

    logic [aw-1:0] tx_rd_ptr, tx_wr_ptr;
    logic [aw-1:0] rx_rd_ptr, rx_wr_ptr;
    logic [cw-1:0] tx_count, rx_count;

    logic tx_do_pop, tx_do_wr, tx_drop;
    logic rx_match, rx_in;
    logic rx_do_rd, rx_do_wr, rx_drop;
    logic [16:0] drop_sum;

    function automatic logic [aw-1:0] next_ptr(input logic [aw-1:0] p);
        return (p == last_ptr) ? '0 : p + aw'(1);
    endfunction

    // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the
    // slot the same-cycle write lands in.
    assign tx_do_pop = pop & (tx_count != '0);
    assign tx_do_wr  = tx_wr & ((tx_count != full_cnt) | tx_do_pop);
    assign tx_drop   = tx_wr & ~tx_do_wr;

    assign rx_match = (D_push[pckg_sz-1 -: 8] == id) |
                      (D_push[pckg_sz-1 -: 8] == bc_id);
    assign rx_in    = push & rx_match;
    assign rx_do_rd = rx_rd & (rx_count != '0);
    assign rx_do_wr = rx_in & ((rx_count != full_cnt) | rx_do_rd);
    assign rx_drop  = rx_in & ~rx_do_wr;

    assign drop_sum = {1'b0, drop_cnt} + {16'd0, tx_drop} + {16'd0, rx_drop};

    assign pndng    = (tx_count != '0);
    assign tx_full  = (tx_count == full_cnt);
    assign D_pop    = tx_mem[tx_rd_ptr];
    assign rx_valid = (rx_count != '0);
    assign rx_full  = (rx_count == full_cnt);
    assign rx_data  = rx_mem[rx_rd_ptr];

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_do_wr)
                tx_wr_ptr <= next_ptr(tx_wr_ptr);
            if (tx_do_pop)
                tx_rd_ptr <= next_ptr(tx_rd_ptr);
            case ({tx_do_wr, tx_do_pop})
                2'b10:   tx_count <= tx_count + cw'(1);
                2'b01:   tx_count <= tx_count - cw'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_do_wr)
                rx_wr_ptr <= next_ptr(rx_wr_ptr);
            if (rx_do_rd)
                rx_rd_ptr <= next_ptr(rx_rd_ptr);
            case ({rx_do_wr, rx_do_rd})
                2'b10:   rx_count <= rx_count + cw'(1);
                2'b01:   rx_count <= rx_count - cw'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Storage arrays; contents survive reset, only accepted writes land
    always_ff @(posedge clk) begin
        if (!reset && tx_do_wr)
            tx_mem[tx_wr_ptr] <= tx_data;
        if (!reset && rx_do_wr)
            rx_mem[rx_wr_ptr] <= D_push;
    end

    // Overflow pulses and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            tx_ovf   <= tx_drop;
            rx_ovf   <= rx_drop;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_bus_port_fifo.sv
// tb_bus_port_fifo: directed and randomized checks of bus_port_fifo
// against a queue-based reference model.
module tb_bus_port_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_wr = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_full;
    logic        pndng;
    logic [15:0] d_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [15:0] d_push = '0;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_rd = 1'b0;
    logic        rx_full;
    logic        tx_ovf;
    logic        rx_ovf;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_tx[$];
    logic [15:0] m_rx[$];
    int          m_drop = 0;
    bit          m_tx_ovf = 0;
    bit          m_rx_ovf = 0;

    bus_port_fifo #(
        .pckg_sz(16),
        .depth  (DEPTH),
        .id     (8'h02),
        .bc_id  (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_wr   (tx_wr),
        .tx_data (tx_data),
        .tx_full (tx_full),
        .pndng   (pndng),
        .D_pop   (d_pop),
        .pop     (pop),
        .push    (push),
        .D_push  (d_push),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_rd   (rx_rd),
        .rx_full (rx_full),
        .tx_ovf  (tx_ovf),
        .rx_ovf  (rx_ovf),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: apply one clock worth of inputs to the queues
    function automatic void model_step();
        bit tp, ta, rp, ra, rm;
        if (reset) begin
            m_tx.delete();
            m_rx.delete();
            m_drop = 0;
            m_tx_ovf = 0;
            m_rx_ovf = 0;
        end else begin
            tp = pop && (m_tx.size() > 0);
            ta = tx_wr && ((m_tx.size() < DEPTH) || tp);
            rm = push && ((d_push[15:8] == 8'h02) || (d_push[15:8] == 8'hFF));
            rp = rx_rd && (m_rx.size() > 0);
            ra = rm && ((m_rx.size() < DEPTH) || rp);
            m_tx_ovf = tx_wr && !ta;
            m_rx_ovf = rm && !ra;
            if (tp) void'(m_tx.pop_front());
            if (ta) m_tx.push_back(tx_data);
            if (rp) void'(m_rx.pop_front());
            if (ra) m_rx.push_back(d_push);
            m_drop = m_drop + int'(m_tx_ovf) + int'(m_rx_ovf);
            if (m_drop > 65535) m_drop = 65535;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; tx_wr = 1; push = 1; d_push = 16'h02AA; pop = 1;
        tick();
        tick();
        checks++;
        if (pndng !== 1'b0) begin failures++; $display("FAIL reset_pndng got=%b exp=0", pndng); end
        checks++;
        if (tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++;
        if (rx_full !== 1'b0) begin failures++; $display("FAIL reset_rx_full got=%b exp=0", rx_full); end
        checks++;
        if ({tx_ovf, rx_ovf} !== 2'b00) begin failures++; $display("FAIL reset_ovf got=%b%b exp=00", tx_ovf, rx_ovf); end
        checks++;
        if (drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop got=%h exp=0000", drop_cnt); end
        idle_inputs();
    endtask

    task automatic test_basic();
        logic [15:0] exp [3];
        exp[0] = 16'h01AA; exp[1] = 16'h02BB; exp[2] = 16'h03CC;
        do_reset();
        tx_wr = 1; tx_data = exp[0];
        tick();
        checks++;
        if (pndng !== 1'b1) begin failures++; $display("FAIL basic_pndng got=%b exp=1", pndng); end
        tx_data = exp[1]; tick();
        tx_data = exp[2]; tick();
        tx_wr = 0; pop = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (d_pop !== exp[i]) begin failures++; $display("FAIL basic_d_pop%0d got=%h exp=%h", i, d_pop, exp[i]); end
            tick();
        end
        pop = 0;
        checks++;
        if (pndng !== 1'b0) begin failures++; $display("FAIL basic_empty got=%b exp=0", pndng); end
    endtask

    task automatic test_tx_overflow();
        do_reset();
        tx_wr = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tx_data = 16'h1000 + 16'(i);
            tick();
        end
        checks++;
        if (tx_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", tx_full); end
        tx_data = 16'hDEAD;
        tick();
        checks++;
        if (tx_ovf !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", tx_ovf); end
        checks++;
        if (drop_cnt !== 16'd1) begin failures++; $display("FAIL ovf_drop got=%h exp=0001", drop_cnt); end
        tx_wr = 0;
        tick();
        checks++;
        if (tx_ovf !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", tx_ovf); end
        tx_wr = 1; pop = 1; tx_data = 16'h1008;
        tick();
        checks++;
        if (tx_ovf !== 1'b0) begin failures++; $display("FAIL ovf_poprw got=%b exp=0", tx_ovf); end
        checks++;
        if (tx_full !== 1'b1) begin failures++; $display("FAIL ovf_still_full got=%b exp=1", tx_full); end
        tx_wr = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (d_pop !== 16'h1000 + 16'(i)) begin failures++; $display("FAIL ovf_order%0d got=%h exp=%h", i, d_pop, 16'h1000 + 16'(i)); end
            tick();
        end
        pop = 0;
        checks++;
        if (pndng !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", pndng); end
    endtask

    task automatic test_rx_filter();
        logic [15:0] in [4];
        logic [15:0] exp [3];
        in[0] = 16'h0211; in[1] = 16'h0522; in[2] = 16'hFF33; in[3] = 16'h0244;
        exp[0] = 16'h0211; exp[1] = 16'hFF33; exp[2] = 16'h0244;
        do_reset();
        push = 1;
        for (int i = 0; i < 4; i++) begin
            d_push = in[i];
            tick();
        end
        push = 0; rx_rd = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin
                failures++; $display("FAIL rx_filter%0d got=%b/%h exp=1/%h", i, rx_valid, rx_data, exp[i]);
            end
            tick();
        end
        rx_rd = 0;
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_filter_empty got=%b exp=0", rx_valid); end
        checks++;
        if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rx_filter_drop got=%h exp=0000", drop_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        tx_wr = 1;
        for (int i = 0; i < 5; i++) begin tx_data = 16'h0200 + 16'(i); tick(); end
        tx_wr = 0; pop = 1;
        for (int i = 0; i < 3; i++) tick();
        pop = 0; tx_wr = 1;
        for (int i = 5; i < 11; i++) begin tx_data = 16'h0200 + 16'(i); tick(); end
        tx_wr = 0;
        checks++;
        if (tx_full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%b exp=1", tx_full); end
        pop = 1;
        for (int i = 3; i < 11; i++) begin
            checks++;
            if (d_pop !== 16'h0200 + 16'(i)) begin failures++; $display("FAIL wrap_order%0d got=%h exp=%h", i, d_pop, 16'h0200 + 16'(i)); end
            tick();
        end
        pop = 0;
        checks++;
        if (pndng !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", pndng); end
    endtask

    task automatic fill_both();
        tx_wr = 1; push = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tx_data = 16'h3000 + 16'(i);
            d_push  = 16'h0200 + 16'(i);
            tick();
        end
    endtask

    task automatic test_dual_overflow();
        do_reset();
        fill_both();
        checks++;
        if ({tx_full, rx_full} !== 2'b11) begin failures++; $display("FAIL dual_full got=%b%b exp=11", tx_full, rx_full); end
        d_push = 16'hFF99;
        tick();
        checks++;
        if ({tx_ovf, rx_ovf} !== 2'b11) begin failures++; $display("FAIL dual_ovf got=%b%b exp=11", tx_ovf, rx_ovf); end
        checks++;
        if (drop_cnt !== 16'd2) begin failures++; $display("FAIL dual_drop got=%h exp=0002", drop_cnt); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_wr = 1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 16'h4000 + 16'(i);
            push = (i < 3);
            d_push = 16'h0250 + 16'(i);
            tick();
        end
        reset = 1; tx_wr = 1; push = 1; tx_data = 16'h5555; d_push = 16'h0266;
        tick();
        idle_inputs();
        checks++;
        if ({pndng, rx_valid} !== 2'b00) begin failures++; $display("FAIL midrst_flags got=%b%b exp=00", pndng, rx_valid); end
        checks++;
        if (drop_cnt !== 16'd0) begin failures++; $display("FAIL midrst_drop got=%h exp=0000", drop_cnt); end
        tx_wr = 1; tx_data = 16'hBEEF;
        tick();
        tx_wr = 0;
        checks++;
        if (pndng !== 1'b1 || d_pop !== 16'hBEEF) begin failures++; $display("FAIL midrst_head got=%b/%h exp=1/beef", pndng, d_pop); end
    endtask

    task automatic test_saturation();
        do_reset();
        fill_both();
        d_push = 16'h02EE;
        for (int i = 0; i < 32767; i++) tick();
        checks++;
        if (drop_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_fffe got=%h exp=fffe", drop_cnt); end
        tick();
        checks++;
        if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_ffff got=%h exp=ffff", drop_cnt); end
        tick();
        checks++;
        if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", drop_cnt); end
        idle_inputs();
    endtask

    task automatic test_random();
        int wr_pct, rd_pct;
        logic [7:0] hdr;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wr_pct = ((i / 500) % 2 == 0) ? 70 : 30;
            rd_pct = 100 - wr_pct;
            reset   = ($urandom_range(0, 199) == 0);
            tx_wr   = ($urandom_range(0, 99) < wr_pct);
            pop     = ($urandom_range(0, 99) < rd_pct);
            push    = ($urandom_range(0, 99) < wr_pct);
            rx_rd   = ($urandom_range(0, 99) < rd_pct);
            tx_data = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       hdr = 8'h02;
                1:       hdr = 8'hFF;
                2:       hdr = 8'h05;
                default: hdr = 8'($urandom);
            endcase
            d_push = {hdr, 8'($urandom)};
            tick();
            checks++;
            if (pndng !== (m_tx.size() != 0) || tx_full !== (m_tx.size() == DEPTH)) begin
                failures++; $display("FAIL rnd_tx_flags cyc=%0d got=%b%b exp=%b%b", i, pndng, tx_full, m_tx.size() != 0, m_tx.size() == DEPTH);
            end
            checks++;
            if (rx_valid !== (m_rx.size() != 0) || rx_full !== (m_rx.size() == DEPTH)) begin
                failures++; $display("FAIL rnd_rx_flags cyc=%0d got=%b%b exp=%b%b", i, rx_valid, rx_full, m_rx.size() != 0, m_rx.size() == DEPTH);
            end
            if (m_tx.size() != 0) begin
                checks++;
                if (d_pop !== m_tx[0]) begin failures++; $display("FAIL rnd_d_pop cyc=%0d got=%h exp=%h", i, d_pop, m_tx[0]); end
            end
            if (m_rx.size() != 0) begin
                checks++;
                if (rx_data !== m_rx[0]) begin failures++; $display("FAIL rnd_rx_data cyc=%0d got=%h exp=%h", i, rx_data, m_rx[0]); end
            end
            checks++;
            if (tx_ovf !== m_tx_ovf || rx_ovf !== m_rx_ovf) begin
                failures++; $display("FAIL rnd_ovf cyc=%0d got=%b%b exp=%b%b", i, tx_ovf, rx_ovf, m_tx_ovf, m_rx_ovf);
            end
            checks++;
            if (drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL rnd_drop cyc=%0d got=%h exp=%h", i, drop_cnt, 16'(m_drop)); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tx_overflow();
        test_rx_filter();
        test_wrap();
        test_dual_overflow();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_port_fifo.md
# bus_port_fifo

Per-device port adapter sitting directly between one device and one port of the `bs_gnrtr_n_rbtr` bus (one instance per driver index, `drvrs` instances in total).
- Transmit side: buffers outgoing packets and presents them to the bus through the `pndng`/`pop`/`D_pop` handshake.
- Receive side: captures packets the bus delivers with `push`/`D_push`, keeps only those addressed to this port or broadcast, and queues them for the device.
- Saturating drop counters make overflow visible to the scoreboard.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID field.
- `depth`, 8: entries per FIFO (TX and RX each); power of two, at least 2.
- `id`, 0: this port's 8-bit address.
- `bc_id`, 8'hFF: broadcast address, accepted by every port.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `tx_wr`, in, 1: device writes `tx_data` into the TX FIFO.
- `tx_data`, in, pckg_sz: outgoing packet.
- `tx_full`, out, 1: TX FIFO holds `depth` entries.
- `pndng`, out, 1: TX FIFO not empty; to bus.
- `D_pop`, out, pckg_sz: TX head entry; to bus.
- `pop`, in, 1: bus consumes the TX head.
- `push`, in, 1: bus delivers `D_push`.
- `D_push`, in, pckg_sz: incoming packet.
- `rx_valid`, out, 1: RX FIFO not empty.
- `rx_data`, out, pckg_sz: RX head entry.
- `rx_rd`, in, 1: device consumes the RX head.
- `rx_full`, out, 1: RX FIFO holds `depth` entries.
- `tx_ovf`, out, 1: one-cycle pulse when a TX write is dropped.
- `rx_ovf`, out, 1: one-cycle pulse when a matching RX packet is dropped.
- `drop_cnt`, out, 16: saturating count of all dropped packets (TX and RX).

## Operation
- Both FIFOs are circular buffers with read pointer, write pointer and a count register of width clog2(depth)+1. Pointers wrap from depth-1 to 0.
- Both FIFOs are first-word-fall-through:
  - `D_pop` always shows `mem[rd_ptr]`; `rx_data` likewise.
  - Both are don't-care while empty; the bench must not check them then.
- Flags are decoded from registered counts: `pndng` = (tx_count != 0), `tx_full` = (tx_count == depth), and the same for `rx_valid` / `rx_full`.
- TX write:
  - Accepted if `tx_wr` and (not full, or `pop` in the same cycle while non-empty).
  - Full with no `pop`: the write is dropped, `tx_ovf` pulses and `drop_cnt` increments.
- TX pop: `pop` while `pndng` advances `rd_ptr`. `pop` while empty is ignored, with no state change and no error.
- Simultaneous write and pop:
  - Count is unchanged and both pointers advance.
  - Empty case: the pop is ignored and the write is accepted, so count becomes 1.
- RX filter: on a `push` cycle, `D_push` matches when D_push[pckg_sz-1:pckg_sz-8] == `id` or == `bc_id`. Non-matching packets are silently discarded and not counted.
- RX enqueue and dequeue follow the TX rules, with `push & match` in place of `tx_wr` and `rx_rd` in place of `pop`.
  - Matching push while full with no `rx_rd`: the packet is dropped, `rx_ovf` pulses and `drop_cnt` increments.
- `drop_cnt` saturates at 16'hFFFF.
  - TX drop and RX drop in the same cycle: +2.
  - At 16'hFFFE, a double drop gives 16'hFFFF.
- Reset, including mid-operation:
  - Pointers and counts go to 0.
  - `pndng`, `tx_full`, `rx_valid`, `rx_full`, `tx_ovf`, `rx_ovf` = 0; `drop_cnt` = 0.
  - Memory contents are not cleared.
  - While `reset` is high, `tx_wr`, `pop`, `push` and `rx_rd` are ignored.

## Timing
- All state updates on the rising `clk` edge; no combinational path from any input to any output.
- Write-to-visible latency is 1 cycle:
  - `tx_wr` at edge N makes `pndng`=1 and `D_pop`=data valid after edge N.
  - Likewise, `push` into `rx_valid`/`rx_data`.
- Pop latency:
  - `pop` sampled at edge N presents the next head (or `pndng`=0) after edge N.
  - The bus may pop back-to-back every cycle.
- `tx_ovf`, `rx_ovf` and `drop_cnt` update after the edge that drops the packet.
- Reset is sampled synchronously. Outputs take reset values after the first edge with `reset`=1 and hold them until the first edge with `reset`=0.

## Test plan
- Reset, then write A=16'h01AA, B=16'h02BB, C=16'h03CC one per cycle, then `pop` 3 consecutive cycles:
  - `pndng`=1 one cycle after the first write.
  - `D_pop` = A, B, C in order.
  - `pndng`=0 after the third pop.
- Fill TX with 8 writes (depth=8), then a 9th write with no pop:
  - `tx_full`=1 and `tx_ovf` pulses once.
  - `drop_cnt`=1 and the 9th value is never popped.
  - Repeat at full with `pop`+`tx_wr` in the same cycle: no `tx_ovf`, count stays 8.
- With `id`=2, push 16'h02_11, 16'h05_22, 16'hFF_33, 16'h02_44:
  - `rx_data` yields 0211, FF33, 0244.
  - 0522 is discarded and `drop_cnt` stays 0.
- Write 5 packets, pop 3, write 6 more (pointer wrap), then pop all: 8 packets come out in FIFO order and `pndng`=0 at the end.
- Fill RX (8 matching pushes) and push 1 more matching packet while `rx_rd`=0 in the same cycle as a TX overflow: `rx_ovf`=1, `tx_ovf`=1 and `drop_cnt` +2.
- Assert `reset` for 1 cycle with 4 entries in TX and 3 in RX, with `tx_wr` and `push` active during reset:
  - Afterwards `pndng`=0, `rx_valid`=0 and `drop_cnt`=0.
  - The next write after reset appears as the head.
